// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM pipeline stage: byte-addressable data memory with load/store extraction
// and the MEM/WB pipeline register.
module memory_access #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC3,
  input  logic [31:0] Instr3,
  input  logic [31:0] Result3,
  input  logic [31:0] B3,
  input  logic [4:0]  WA3,
  input  logic [31:0] imm32_3,
  input  logic        ForwardRTM,
  input  logic [31:0] WD,
  output logic [31:0] PC4,
  output logic [31:0] Instr4,
  output logic [31:0] ALURes4,
  output logic [31:0] DMRD4,
  output logic [4:0]  WA4,
  output logic [31:0] imm32_4
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] mem_q [DM_WORDS];

  logic [5:0]    op;
  logic [AW-1:0] idx;
  logic [31:0]   sd;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [4:0]    byte_off;
  logic          store_en;
  logic [31:0]   word_d;

  logic [31:0] pc4_d, pc4_q;
  logic [31:0] instr4_d, instr4_q;
  logic [31:0] alures4_d, alures4_q;
  logic [31:0] dmrd4_d, dmrd4_q;
  logic [4:0]  wa4_d, wa4_q;
  logic [31:0] imm32_4_d, imm32_4_q;

  always_comb begin
    op       = Instr3[31:26];
    idx      = Result3[AW+1:2];
    sd       = ForwardRTM ? WD : B3;
    rd_word  = mem_q[idx];
    byte_off = {Result3[1:0], 3'b000};
    rd_half  = Result3[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte  = rd_word[byte_off +: 8];

    // Stores merge into the pre-edge word so untouched bytes are preserved.
    store_en = 1'b0;
    word_d   = rd_word;
    case (op)
      OP_SW: begin
        store_en = 1'b1;
        word_d   = sd;
      end
      OP_SH: begin
        store_en = 1'b1;
        if (Result3[1]) word_d[31:16] = sd[15:0];
        else            word_d[15:0]  = sd[15:0];
      end
      OP_SB: begin
        store_en = 1'b1;
        word_d[byte_off +: 8] = sd[7:0];
      end
      default: ;
    endcase

    case (op)
      OP_LW:   dmrd4_d = rd_word;
      OP_LH:   dmrd4_d = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  dmrd4_d = {16'h0000, rd_half};
      OP_LB:   dmrd4_d = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  dmrd4_d = {24'h000000, rd_byte};
      default: dmrd4_d = rd_word;
    endcase

    pc4_d     = PC3;
    instr4_d  = Instr3;
    alures4_d = Result3;
    wa4_d     = WA3;
    imm32_4_d = imm32_3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (store_en) begin
      mem_q[idx] <= word_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc4_q     <= '0;
      instr4_q  <= '0;
      alures4_q <= '0;
      dmrd4_q   <= '0;
      wa4_q     <= '0;
      imm32_4_q <= '0;
    end else begin
      pc4_q     <= pc4_d;
      instr4_q  <= instr4_d;
      alures4_q <= alures4_d;
      dmrd4_q   <= dmrd4_d;
      wa4_q     <= wa4_d;
      imm32_4_q <= imm32_4_d;
    end
  end

  assign PC4     = pc4_q;
  assign Instr4  = instr4_q;
  assign ALURes4 = alures4_q;
  assign DMRD4   = dmrd4_q;
  assign WA4     = wa4_q;
  assign imm32_4 = imm32_4_q;

endmodule
